// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the on-chip RAM subordinate.
package axi4_pkg;

   typedef enum logic [1:0] {W_IDLE, W_DATA, B_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/sub_ram.sv
// Simple dual-port RAM: byte-enabled synchronous write, registered read-first read.
// rd_clr zeroes the read register instead of loading it.
module sub_ram #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 256
) (
   input  logic                     clk_i,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [WIDTH/8-1:0]       wr_be,
   input  logic                     rd_en,
   input  logic                     rd_clr,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   localparam int BPW = WIDTH / 8;

   logic [WIDTH-1:0] mem [DEPTH];

   // Read and write share one process so a same-address collision returns old data.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < BPW; i++) begin
         if (wr_en && wr_be[i]) begin
            mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
         end
      end
      if (rd_clr) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axi4_sub_ram.sv
// AXI4 subordinate backed by an on-chip RAM; one outstanding burst per direction.
// Define AXI4_SUB_RANGE_ERR_EN to drop out-of-range beats and answer SLVERR.
module axi4_sub_ram #(
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        AXI_DATA_WIDTH = 64,
   parameter int                        AXI_ID_WIDTH   = 4,
   parameter int                        MEM_DEPTH      = 256,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [AXI_ID_WIDTH-1:0]     aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]                  aw_len,
   input  logic [2:0]                  aw_size,
   input  logic [1:0]                  aw_burst,
   input  logic                        aw_lock,
   input  logic [3:0]                  aw_cache,
   input  logic [2:0]                  aw_prot,
   input  logic                        aw_valid,
   output logic                        aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
   input  logic                        w_last,
   input  logic                        w_valid,
   output logic                        w_ready,
   output logic [AXI_ID_WIDTH-1:0]     b_id,
   output logic [1:0]                  b_resp,
   output logic                        b_valid,
   input  logic                        b_ready,
   input  logic [AXI_ID_WIDTH-1:0]     ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]                  ar_len,
   input  logic [2:0]                  ar_size,
   input  logic [1:0]                  ar_burst,
   input  logic                        ar_lock,
   input  logic [3:0]                  ar_cache,
   input  logic [2:0]                  ar_prot,
   input  logic                        ar_valid,
   output logic                        ar_ready,
   output logic [AXI_ID_WIDTH-1:0]     r_id,
   output logic [AXI_DATA_WIDTH-1:0]   r_data,
   output logic [1:0]                  r_resp,
   output logic                        r_last,
   output logic                        r_valid,
   input  logic                        r_ready,
   output logic                        wr_busy_o,
   output logic                        rd_busy_o
);

   import axi4_pkg::*;

   localparam int BPW     = AXI_DATA_WIDTH / 8;
   localparam int LOG_BPW = $clog2(BPW);
   localparam int IDX_W   = $clog2(MEM_DEPTH);
`ifdef AXI4_SUB_RANGE_ERR_EN
   // One spare bit keeps the unwrapped word offset from rolling over mid-burst.
   localparam int CNT_W = AXI_ADDR_WIDTH - LOG_BPW + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);
`else
   localparam int CNT_W = IDX_W;
`endif

   wr_state_t wr_state_reg, wr_state_next;
   rd_state_t rd_state_reg, rd_state_next;

   logic [AXI_ADDR_WIDTH-1:0] aw_off, ar_off;
   logic [CNT_W-1:0]          wr_idx_reg, rd_idx_reg;
   logic [7:0]                wr_len_reg, wr_cnt_reg, rd_len_reg, rd_cnt_reg;
   logic                      wr_err_reg;
   logic                      aw_hs, ar_hs, wr_beat, r_hs;
   logic                      wr_beat_oor, rd_beat_oor;
   logic                      aw_ready_next, w_ready_next, b_valid_next;
   logic                      ar_ready_next, r_valid_next, r_last_next;
   logic [1:0]                b_resp_next, r_resp_next;
   logic                      unused_ok;

   assign aw_off  = aw_addr - BASE_ADDR;
   assign ar_off  = ar_addr - BASE_ADDR;
   assign aw_hs   = aw_valid & aw_ready;
   assign ar_hs   = ar_valid & ar_ready;
   assign wr_beat = w_valid & w_ready;
   assign r_hs    = r_valid & r_ready;

   assign wr_busy_o = (wr_state_reg != W_IDLE);
   assign rd_busy_o = (rd_state_reg != R_IDLE);

   assign unused_ok = ^{aw_size, aw_burst, aw_lock, aw_cache, aw_prot, w_last,
                        ar_size, ar_burst, ar_lock, ar_cache, ar_prot};

`ifdef AXI4_SUB_RANGE_ERR_EN
   logic wr_below_reg, rd_below_reg;

   assign wr_beat_oor = wr_below_reg | (wr_idx_reg >= DEPTH_C);
   assign rd_beat_oor = rd_below_reg | (rd_idx_reg >= DEPTH_C);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_below_reg <= 1'b0;
         rd_below_reg <= 1'b0;
      end else begin
         if (aw_hs) wr_below_reg <= (aw_addr < BASE_ADDR);
         if (ar_hs) rd_below_reg <= (ar_addr < BASE_ADDR);
      end
   end
`else
   assign wr_beat_oor = 1'b0;
   assign rd_beat_oor = 1'b0;
`endif

   // Write FSM next-state
   always_comb begin
      wr_state_next = wr_state_reg;
      case (wr_state_reg)
         W_IDLE:  if (aw_hs) wr_state_next = W_DATA;
         W_DATA:  if (wr_beat && (wr_cnt_reg == wr_len_reg)) wr_state_next = B_RESP;
         B_RESP:  if (b_valid && b_ready) wr_state_next = W_IDLE;
         default: wr_state_next = W_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they leave the register stage aligned with it.
   always_comb begin
      aw_ready_next = (wr_state_next == W_IDLE);
      w_ready_next  = (wr_state_next == W_DATA);
      b_valid_next  = (wr_state_next == B_RESP);
      b_resp_next   = (b_valid_next && (wr_err_reg || (wr_beat && wr_beat_oor)))
                      ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_state_reg <= W_IDLE;
         aw_ready     <= 1'b0;
         w_ready      <= 1'b0;
         b_valid      <= 1'b0;
         b_resp       <= AXI_RESP_OKAY;
         b_id         <= '0;
         wr_len_reg   <= '0;
         wr_cnt_reg   <= '0;
         wr_idx_reg   <= '0;
         wr_err_reg   <= 1'b0;
      end else begin
         wr_state_reg <= wr_state_next;
         aw_ready     <= aw_ready_next;
         w_ready      <= w_ready_next;
         b_valid      <= b_valid_next;
         b_resp       <= b_resp_next;
         if (aw_hs) begin
            b_id       <= aw_id;
            wr_len_reg <= aw_len;
            wr_cnt_reg <= '0;
            wr_idx_reg <= CNT_W'(aw_off >> LOG_BPW);
            wr_err_reg <= 1'b0;
         end
         if (wr_beat) begin
            wr_cnt_reg <= wr_cnt_reg + 8'd1;
            wr_idx_reg <= wr_idx_reg + CNT_W'(1);
            wr_err_reg <= wr_err_reg | wr_beat_oor;
         end
      end
   end

   // Read FSM next-state
   always_comb begin
      rd_state_next = rd_state_reg;
      case (rd_state_reg)
         R_IDLE:  if (ar_hs) rd_state_next = R_FETCH;
         R_FETCH: rd_state_next = R_DATA;
         R_DATA:  if (r_hs) rd_state_next = (rd_cnt_reg == rd_len_reg) ? R_IDLE : R_FETCH;
         default: rd_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      ar_ready_next = (rd_state_next == R_IDLE);
      r_valid_next  = (rd_state_next == R_DATA);
      r_last_next   = r_valid_next && (rd_cnt_reg == rd_len_reg);
      r_resp_next   = (r_valid_next && rd_beat_oor) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_state_reg <= R_IDLE;
         ar_ready     <= 1'b0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_resp       <= AXI_RESP_OKAY;
         r_id         <= '0;
         rd_len_reg   <= '0;
         rd_cnt_reg   <= '0;
         rd_idx_reg   <= '0;
      end else begin
         rd_state_reg <= rd_state_next;
         ar_ready     <= ar_ready_next;
         r_valid      <= r_valid_next;
         r_last       <= r_last_next;
         r_resp       <= r_resp_next;
         if (ar_hs) begin
            r_id       <= ar_id;
            rd_len_reg <= ar_len;
            rd_cnt_reg <= '0;
            rd_idx_reg <= CNT_W'(ar_off >> LOG_BPW);
         end
         if (r_hs) begin
            rd_cnt_reg <= rd_cnt_reg + 8'd1;
            rd_idx_reg <= rd_idx_reg + CNT_W'(1);
         end
      end
   end

   // The RAM read register doubles as r_data; it is only reloaded in R_FETCH, so it holds through stalls.
   sub_ram #(
      .WIDTH (AXI_DATA_WIDTH),
      .DEPTH (MEM_DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .wr_en   (wr_beat & ~wr_beat_oor),
      .wr_addr (wr_idx_reg[IDX_W-1:0]),
      .wr_data (w_data),
      .wr_be   (w_strb),
      .rd_en   (rd_state_reg == R_FETCH),
      .rd_clr  (rst_i | ((rd_state_reg == R_FETCH) & rd_beat_oor)),
      .rd_addr (rd_idx_reg[IDX_W-1:0]),
      .rd_data (r_data)
   );

endmodule

// File: tb/tb_axi4_sub_ram.sv
// Directed bench for axi4_sub_ram with a reference memory model and B/R scoreboards.
// Expectations follow AXI4_SUB_RANGE_ERR_EN when it is defined for the build.
module tb_axi4_sub_ram;

   localparam int DEPTH = 256;
`ifdef AXI4_SUB_RANGE_ERR_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [3:0]  aw_id, ar_id, b_id, r_id;
   logic [31:0] aw_addr, ar_addr;
   logic [7:0]  aw_len, ar_len, w_strb;
   logic [63:0] w_data, r_data;
   logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
   logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
   logic [1:0]  b_resp, r_resp;
   logic        wr_busy_o, rd_busy_o;

   always #5 clk_i = ~clk_i;

   axi4_sub_ram dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(3'd3), .aw_burst(2'b01),
      .aw_lock(1'b0), .aw_cache(4'd0), .aw_prot(3'd0), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(3'd3), .ar_burst(2'b01),
      .ar_lock(1'b0), .ar_cache(4'd0), .ar_prot(3'd0), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
      .wr_busy_o(wr_busy_o), .rd_busy_o(rd_busy_o)
   );

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rexp_t;

   typedef struct {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   rexp_t       rq[$];
   bexp_t       bq[$];
   logic [63:0] mdl [DEPTH];
   logic [63:0] wbuf [8];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit beat_oor(input logic [31:0] addr, input int beat);
      int w;
      w = int'(addr >> 3) + beat;
      return RANGE_EN && (w >= DEPTH);
   endfunction

   function automatic int beat_idx(input logic [31:0] addr, input int beat);
      return (int'(addr >> 3) + beat) % DEPTH;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [7:0] strb, input int bstall);
      bexp_t be;
      bexp_t got;
      int    n;
      be.resp = 2'b00;
      be.id   = id;
      for (int i = 0; i <= len; i++) if (beat_oor(addr, i)) be.resp = 2'b10;
      bq.push_back(be);
      aw_addr = addr; aw_id = id; aw_len = 8'(len); aw_valid = 1'b1;
      n = 0;
      while (!aw_ready && n < 100) begin tick(); n++; end
      chk("aw_ready_wait", aw_ready, 1);
      tick();
      aw_valid = 1'b0;
      chk("w_ready_t1", w_ready, 1);
      chk("wr_busy", wr_busy_o, 1);
      for (int i = 0; i <= len; i++) begin
         w_data = wbuf[i]; w_strb = strb; w_last = (i == len); w_valid = 1'b1;
         n = 0;
         while (!w_ready && n < 100) begin tick(); n++; end
         chk("w_ready_wait", w_ready, 1);
         tick();
      end
      w_valid = 1'b0; w_last = 1'b0;
      chk("b_valid_u1", b_valid, 1);
      chk("aw_ready_busy", aw_ready, 0);
      for (int s = 0; s < bstall; s++) begin
         chk("b_hold_valid", b_valid, 1);
         chk("b_hold_aw_ready", aw_ready, 0);
         tick();
      end
      got = bq.pop_front();
      chk("b_resp", b_resp, got.resp);
      chk("b_id", b_id, got.id);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      chk("b_valid_drop", b_valid, 0);
      chk("aw_ready_back", aw_ready, 1);
      for (int i = 0; i <= len; i++) begin
         if (!beat_oor(addr, i)) begin
            for (int b = 0; b < 8; b++) begin
               if (strb[b]) mdl[beat_idx(addr, i)][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
         end
      end
      $display("WR addr=%08h id=%0d len=%0d strb=%02h resp=%0d", addr, id, len, strb, got.resp);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input int stall_beat, input int stall);
      rexp_t e;
      int    n;
      for (int i = 0; i <= len; i++) begin
         e.last = (i == len);
         e.id   = id;
         if (beat_oor(addr, i)) begin
            e.data = 64'd0; e.resp = 2'b10;
         end else begin
            e.data = mdl[beat_idx(addr, i)]; e.resp = 2'b00;
         end
         rq.push_back(e);
      end
      ar_addr = addr; ar_id = id; ar_len = 8'(len); ar_valid = 1'b1;
      n = 0;
      while (!ar_ready && n < 100) begin tick(); n++; end
      chk("ar_ready_wait", ar_ready, 1);
      tick();
      ar_valid = 1'b0;
      chk("r_valid_t1", r_valid, 0);
      tick();
      chk("r_valid_t2", r_valid, 1);
      chk("ar_ready_busy", ar_ready, 0);
      for (int i = 0; i <= len; i++) begin
         n = 0;
         while (!r_valid && n < 100) begin tick(); n++; end
         chk("r_valid_wait", r_valid, 1);
         e = rq.pop_front();
         if (i == stall_beat) begin
            for (int s = 0; s < stall; s++) begin
               chk("r_hold_valid", r_valid, 1);
               chk("r_hold_data", r_data, e.data);
               tick();
            end
         end
         chk("r_data", r_data, e.data);
         chk("r_resp", r_resp, e.resp);
         chk("r_last", r_last, e.last);
         chk("r_id", r_id, e.id);
         r_ready = 1'b1;
         tick();
         r_ready = 1'b0;
         chk("r_valid_gap", r_valid, 0);
         $display("RD addr=%08h id=%0d beat=%0d data=%016h resp=%0d last=%0d",
                  addr, id, i, e.data, e.resp, e.last);
      end
      chk("ar_ready_back", ar_ready, 1);
   endtask

   initial begin
      aw_id = '0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
      w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
      ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0; r_ready = 1'b0;
      rst_i = 1'b1;
      repeat (3) tick();
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_last", r_last, 0);
      chk("rst_r_data", r_data, 0);
      chk("rst_b_resp", b_resp, 0);
      chk("rst_r_resp", r_resp, 0);
      chk("rst_b_id", b_id, 0);
      chk("rst_r_id", r_id, 0);
      chk("rst_wr_busy", wr_busy_o, 0);
      chk("rst_rd_busy", rd_busy_o, 0);
      rst_i = 1'b0;
      tick();
      chk("post_rst_aw_ready", aw_ready, 1);
      chk("post_rst_ar_ready", ar_ready, 1);

      // single beat write then read back
      wbuf[0] = 64'hDEAD_BEEF_0123_4567;
      do_write(32'h10, 4'h5, 0, 8'hFF, 0);
      do_read(32'h10, 4'h9, 0, -1, 0);

      // four-beat INCR burst
      for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
      do_write(32'h0, 4'h2, 3, 8'hFF, 0);
      do_read(32'h0, 4'h3, 3, -1, 0);

      // partial strobe over an all-ones word
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      do_write(32'h40, 4'h1, 0, 8'hFF, 0);
      wbuf[0] = 64'h0;
      do_write(32'h40, 4'h1, 0, 8'h0F, 0);
      do_read(32'h40, 4'h4, 0, -1, 0);

      // back-pressure on B and mid-burst on R
      wbuf[0] = 64'h0BAD_F00D_CAFE_1234;
      do_write(32'h80, 4'hC, 0, 8'hFF, 5);
      do_read(32'h0, 4'hD, 3, 1, 3);

      // same-cycle write and read of one word: read sees the old contents
      wbuf[0] = 64'h55;
      do_write(32'h100, 4'h6, 0, 8'hFF, 0);
      wbuf[0] = 64'hAA;
      fork
         do_write(32'h100, 4'h6, 0, 8'hFF, 0);
         do_read(32'h100, 4'h7, 0, -1, 0);
      join
      do_read(32'h100, 4'h7, 0, -1, 0);

      // one word past the RAM: aliases word 0 or is rejected
      wbuf[0] = 64'h1234;
      do_write(32'h800, 4'h8, 0, 8'hFF, 0);
      do_read(32'h0, 4'hA, 0, -1, 0);
      do_read(32'h800, 4'hB, 0, -1, 0);

      // reset with both channels mid-burst
      aw_addr = 32'h200; aw_id = 4'h1; aw_len = 8'd3; aw_valid = 1'b1;
      tick();
      aw_valid = 1'b0;
      w_data = 64'h77; w_strb = 8'hFF; w_valid = 1'b1;
      ar_addr = 32'h0; ar_id = 4'h2; ar_len = 8'd3; ar_valid = 1'b1;
      tick();
      w_valid = 1'b0; ar_valid = 1'b0;
      chk("mid_wr_busy", wr_busy_o, 1);
      chk("mid_rd_busy", rd_busy_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("mid_rst_aw_ready", aw_ready, 0);
      chk("mid_rst_w_ready", w_ready, 0);
      chk("mid_rst_b_valid", b_valid, 0);
      chk("mid_rst_ar_ready", ar_ready, 0);
      chk("mid_rst_r_valid", r_valid, 0);
      chk("mid_rst_wr_busy", wr_busy_o, 0);
      chk("mid_rst_rd_busy", rd_busy_o, 0);
      tick();
      chk("mid_rst_aw_back", aw_ready, 1);
      chk("mid_rst_ar_back", ar_ready, 1);
      do_read(32'h10, 4'h9, 0, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
